// File: rtl/pll_dphase_pkg.sv
// rtl/pll_dphase_pkg.sv - shared types and constants for the PLL dynamic phase-shift sequencer
package pll_dphase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_LOAD,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic OP_STEP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_dphase_pos.sv
// rtl/pll_dphase_pos.sv - modulo-PERIOD up/down phase position counter for one PLL output
module pll_dphase_pos #(
  parameter int                   PHASE_W = 10,
  parameter logic [PHASE_W-1:0]   PERIOD  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  output logic [PHASE_W-1:0] pos
);

  localparam logic [PHASE_W-1:0] LAST = PERIOD - 1'b1;

  // Wrap is detected before the add so the counter never leaves [0, PERIOD-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= (pos == LAST) ? '0 : pos + 1'b1;
    end else if (dec) begin
      pos <= (pos == '0) ? LAST : pos - 1'b1;
    end
  end

endmodule

// File: rtl/pll_dphase_ctrl.sv
// rtl/pll_dphase_ctrl.sv - sequencer for the EHXPLLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG port
module pll_dphase_ctrl
  import pll_dphase_pkg::*;
#(
  parameter int                     NCH          = 4,
  parameter int                     PHASE_W      = 10,
  parameter int                     CNT_W        = 8,
  parameter logic [NCH*PHASE_W-1:0] PERIOD_STEPS = {NCH{10'd24}},
  parameter int                     SETUP_CYC    = 2,
  parameter int                     PULSE_CYC    = 2,
  parameter int                     GAP_CYC      = 4,
  localparam int                    CHW          = $clog2(NCH) | 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [CHW-1:0]           req_ch,
  input  logic                     req_dir,
  input  logic [CNT_W-1:0]         req_count,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               phasesel,
  output logic                     phasedir,
  output logic                     phasestep,
  output logic                     phaseloadreg,
  output logic [NCH*PHASE_W-1:0]   pos
);

  localparam int TW = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

  state_t           state, state_n, start_st;
  logic [TW-1:0]    tmr;
  logic             op_q, dir_q;
  logic [CHW-1:0]   ch_q;
  logic [CNT_W-1:0] rem_q;
  logic             accept, bad_ch, null_req;
  logic             strobe_end, step_fire, load_fire;

  assign accept   = req_valid && req_ready;
  assign bad_ch   = int'(req_ch) >= NCH;
  assign null_req = bad_ch || (req_op == OP_STEP && req_count == '0);
  assign start_st = null_req ? ST_DONE : ST_SETUP;

  assign strobe_end = (state == ST_PULSE || state == ST_LOAD) && tmr == TW'(PULSE_CYC - 1);
  assign step_fire  = strobe_end && state == ST_PULSE;
  assign load_fire  = strobe_end && state == ST_LOAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = start_st;
      ST_SETUP: if (tmr == TW'(SETUP_CYC - 1)) state_n = (op_q == OP_LOAD) ? ST_LOAD : ST_PULSE;
      ST_PULSE,
      ST_LOAD:  if (strobe_end) state_n = ST_GAP;
      ST_GAP:   if (tmr == TW'(GAP_CYC - 1)) state_n = (rem_q != '0) ? ST_PULSE : ST_DONE;
      ST_DONE:  state_n = accept ? start_st : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Strobes and handshakes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr          <= '0;
      op_q         <= OP_STEP;
      dir_q        <= 1'b0;
      ch_q         <= '0;
      rem_q        <= '0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      phasesel     <= '0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b0;
      phaseloadreg <= 1'b0;
    end else begin
      tmr <= (state_n != state) ? '0 : tmr + 1'b1;
      if (accept) begin
        op_q     <= req_op;
        dir_q    <= req_dir;
        ch_q     <= req_ch;
        // LOAD never loops back into PULSE, so it carries no remaining steps.
        rem_q    <= (req_op == OP_LOAD) ? '0 : req_count;
        phasesel <= 2'(req_ch);
        phasedir <= req_dir;
      end else if (step_fire) begin
        rem_q <= rem_q - 1'b1;
      end
      req_ready    <= (state_n == ST_IDLE) || (state_n == ST_DONE);
      done         <= (state_n == ST_DONE);
      err          <= accept && bad_ch;
      phasestep    <= (state_n == ST_PULSE);
      phaseloadreg <= (state_n == ST_LOAD);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_pos
    pll_dphase_pos #(
      .PHASE_W (PHASE_W),
      .PERIOD  (PERIOD_STEPS[i*PHASE_W +: PHASE_W])
    ) u_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (step_fire && !dir_q && ch_q == CHW'(i)),
      .dec   (step_fire &&  dir_q && ch_q == CHW'(i)),
      .clr   (load_fire),
      .pos   (pos[i*PHASE_W +: PHASE_W])
    );
  end

endmodule
